// File: rtl/event_dispatcher.sv
// Round-robin dispatcher: hands queued events to free PEs for the active layer,
// tracks per-PE busy state and reports drain status to the layer controller.
module event_dispatcher #(
  parameter int NUM_PE = 4,
  parameter int EVT_W  = 16,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_active,
  input  logic [1:0]        layer_id,
  input  logic              layer_start,
  input  logic              flush,
  input  logic              evt_valid,
  input  logic [EVT_W-1:0]  evt_data,
  output logic              evt_ready,
  input  logic [NUM_PE-1:0] pe_done,
  output logic [NUM_PE-1:0] pe_start,
  output logic [EVT_W-1:0]  pe_evt,
  output logic [1:0]        pe_layer,
  output logic [NUM_PE-1:0] pe_busy,
  output logic              pe_idle,
  output logic [CNT_W-1:0]  dispatch_count,
  output logic              err
);

  localparam int PTR_W = $clog2(NUM_PE);

  logic [NUM_PE-1:0] busy;
  logic [NUM_PE-1:0] free;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  grant_idx;
  logic              found;
  logic [NUM_PE-1:0] grant_oh;
  logic              accept;

  assign free      = ~busy;
  assign evt_ready = layer_active & ~flush & (|free);
  assign accept    = evt_valid & evt_ready;
  assign pe_busy   = busy;
  assign pe_idle   = (busy == '0) && (pe_start == '0);

  // First free PE at or above rr_ptr; pointer arithmetic wraps since NUM_PE is a power of two.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      idx = rr_ptr + PTR_W'(k);
      if (!found && free[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (found) grant_oh[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= '0;
      rr_ptr         <= '0;
      pe_start       <= '0;
      pe_evt         <= '0;
      pe_layer       <= '0;
      dispatch_count <= '0;
      err            <= 1'b0;
    end else begin
      busy <= (busy & ~pe_done) | (accept ? grant_oh : '0);

      if (accept) begin
        pe_start <= grant_oh;
        pe_evt   <= evt_data;
        pe_layer <= layer_id;
        rr_ptr   <= grant_idx + PTR_W'(1);
      end else begin
        pe_start <= '0;
      end

      if (layer_start)
        dispatch_count <= accept ? CNT_W'(1) : '0;
      else if (accept && (dispatch_count != '1))
        dispatch_count <= dispatch_count + CNT_W'(1);

      // A stray completion in the same cycle as layer_start must still be flagged.
      if (|(pe_done & ~busy))
        err <= 1'b1;
      else if (layer_start)
        err <= 1'b0;
    end
  end

endmodule
